// File: rtl/riscv_pkg.sv
// Shared encodings and decode helpers for the RV32I pipeline control path.
package riscv_pkg;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluSlt = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ResAlu = 2'b00,
        ResMem = 2'b01,
        ResPc4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        PcPlus4  = 2'b00,
        PcTarget = 2'b01,
        PcAlu    = 2'b10
    } pcsrc_e;

    typedef enum logic [1:0] {
        ImmI = 2'b00,
        ImmS = 2'b01,
        ImmB = 2'b10,
        ImmJ = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        FwdRf = 2'b00,
        FwdW  = 2'b01,
        FwdM  = 2'b10
    } fwd_e;

    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        jalr;
        alu_ctrl_e   alu_control;
        logic        alu_src;
    } ctrl_t;

    localparam ctrl_t CtrlBubble = '{
        reg_write:   1'b0,
        result_src:  ResAlu,
        mem_write:   1'b0,
        branch:      1'b0,
        jump:        1'b0,
        jalr:        1'b0,
        alu_control: AluAdd,
        alu_src:     1'b0
    };

    function automatic alu_ctrl_e alu_op(logic [2:0] funct3, logic is_sub);
        case (funct3)
            3'b000:  return is_sub ? AluSub : AluAdd;
            3'b010:  return AluSlt;
            3'b110:  return AluOr;
            3'b111:  return AluAnd;
            default: return AluAdd;
        endcase
    endfunction

    function automatic ctrl_t decode_ctrl(logic [31:0] instr);
        ctrl_t c;
        c = CtrlBubble;
        case (instr[6:0])
            OpLoad: begin
                c.reg_write  = 1'b1;
                c.result_src = ResMem;
                c.alu_src    = 1'b1;
            end
            OpStore: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
            end
            OpRtype: begin
                c.reg_write   = 1'b1;
                c.alu_control = alu_op(instr[14:12], instr[30]);
            end
            OpItype: begin
                c.reg_write   = 1'b1;
                c.alu_src     = 1'b1;
                c.alu_control = alu_op(instr[14:12], 1'b0);
            end
            OpBranch: begin
                c.branch      = 1'b1;
                c.alu_control = AluSub;
            end
            OpJal: begin
                c.reg_write  = 1'b1;
                c.result_src = ResPc4;
                c.jump       = 1'b1;
            end
            OpJalr: begin
                c.reg_write  = 1'b1;
                c.result_src = ResPc4;
                c.jalr       = 1'b1;
                c.alu_src    = 1'b1;
            end
            default: c = CtrlBubble;
        endcase
        return c;
    endfunction

    function automatic imm_src_e imm_sel(logic [31:0] instr);
        case (instr[6:0])
            OpStore:  return ImmS;
            OpBranch: return ImmB;
            OpJal:    return ImmJ;
            default:  return ImmI;
        endcase
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// Forwarding, stall/flush arbitration and memory-timeout tracking.
// Build option: PIPE_CTRL_FORWARDING_EN selects forwarding instead of RAW stalling.
module hazard_unit
    import riscv_pkg::*;
#(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1D,
    input  logic [REG_AW-1:0] rs2D,
    input  logic [REG_AW-1:0] rs1E,
    input  logic [REG_AW-1:0] rs2E,
    input  logic [REG_AW-1:0] rdE,
    input  logic              reg_writeE,
    input  logic [1:0]        result_srcE,
    input  logic              branchE,
    input  logic              jumpE,
    input  logic              jalrE,
    input  logic              zeroE,
    input  logic [REG_AW-1:0] rdM,
    input  logic              reg_writeM,
    input  logic              mem_accessM,
    input  logic [REG_AW-1:0] rdW,
    input  logic              reg_writeW,
    input  logic              dmem_ready,
    output logic [1:0]        fwd_aE,
    output logic [1:0]        fwd_bE,
    output logic [1:0]        pcsrcE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic              mem_err
);

    localparam int unsigned CntW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MEM_TIMEOUT);

    logic            mem_wait, taken, load_use, raw_stall;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            mem_err_q, mem_err_d;

    assign mem_wait = mem_accessM & ~dmem_ready;
    assign taken    = jalrE | jumpE | (branchE & zeroE);
    assign load_use = (result_srcE == ResMem) && (rdE != '0) && ((rs1D == rdE) || (rs2D == rdE));

`ifdef PIPE_CTRL_FORWARDING_EN
    logic unused_fwd;
    assign unused_fwd = reg_writeE;
    assign raw_stall  = 1'b0;

    // M-stage result is younger than W, so it wins when both match.
    always_comb begin
        fwd_aE = FwdRf;
        fwd_bE = FwdRf;
        if (rs1E != '0 && reg_writeM && rs1E == rdM) begin
            fwd_aE = FwdM;
        end else if (rs1E != '0 && reg_writeW && rs1E == rdW) begin
            fwd_aE = FwdW;
        end
        if (rs2E != '0 && reg_writeM && rs2E == rdM) begin
            fwd_bE = FwdM;
        end else if (rs2E != '0 && reg_writeW && rs2E == rdW) begin
            fwd_bE = FwdW;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{rs1E, rs2E, rdW, reg_writeW};
    assign fwd_aE     = FwdRf;
    assign fwd_bE     = FwdRf;

    // W needs no stall: the register file writes through to the D-stage read.
    assign raw_stall =
        (reg_writeE && rdE != '0 && (rs1D == rdE || rs2D == rdE)) ||
        (reg_writeM && rdM != '0 && (rs1D == rdM || rs2D == rdM));
`endif

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        pcsrcE = PcPlus4;
        if (mem_wait) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
        end else if (taken) begin
            flushD = 1'b1;
            flushE = 1'b1;
            pcsrcE = jalrE ? PcAlu : PcTarget;
        end else if (load_use || raw_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    always_comb begin
        wait_cnt_d = '0;
        mem_err_d  = mem_err_q;
        if (mem_wait) begin
            wait_cnt_d = (wait_cnt_q == CntMax) ? wait_cnt_q : wait_cnt_q + CntW'(1);
            if (wait_cnt_d == CntMax) begin
                mem_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;

endmodule

// File: rtl/pipe_controller.sv
// Control path of a 5-stage RV32I pipeline: decode plus E/M/W control registers.
// Build option: define PIPE_CTRL_FORWARDING_EN to forward operands instead of stalling on RAW.
module pipe_controller
    import riscv_pkg::*;
#(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instrD,
    input  logic              zeroE,
    input  logic              dmem_ready,
    output logic [1:0]        imm_srcD,
    output logic [2:0]        alu_controlE,
    output logic              alu_srcE,
    output logic [1:0]        fwd_aE,
    output logic [1:0]        fwd_bE,
    output logic [1:0]        pcsrcE,
    output logic              mem_writeM,
    output logic              reg_writeW,
    output logic [1:0]        result_srcW,
    output logic [REG_AW-1:0] rdW,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic              mem_err
);

    ctrl_t             ctrl_dec;
    logic [REG_AW-1:0] rs1D, rs2D, rdD;

    ctrl_t             ctrl_e_q, ctrl_e_d;
    logic [REG_AW-1:0] rs1_e_q, rs1_e_d, rs2_e_q, rs2_e_d, rd_e_q, rd_e_d;

    logic              reg_write_m_q, reg_write_m_d, mem_write_m_q, mem_write_m_d;
    result_src_e       result_src_m_q, result_src_m_d;
    logic [REG_AW-1:0] rd_m_q, rd_m_d;

    logic              reg_write_w_q, reg_write_w_d;
    result_src_e       result_src_w_q, result_src_w_d;
    logic [REG_AW-1:0] rd_w_q, rd_w_d;

    logic              mem_accessM;

    assign rs1D     = instrD[15 +: REG_AW];
    assign rs2D     = instrD[20 +: REG_AW];
    assign ctrl_dec = decode_ctrl(instrD);
    assign imm_srcD = imm_sel(instrD);
    // Non-writing instructions carry rd=0 so their immediate bits never look like a hazard.
    assign rdD      = ctrl_dec.reg_write ? instrD[7 +: REG_AW] : '0;

    always_comb begin
        ctrl_e_d = ctrl_e_q;
        rs1_e_d  = rs1_e_q;
        rs2_e_d  = rs2_e_q;
        rd_e_d   = rd_e_q;
        if (flushE) begin
            ctrl_e_d = CtrlBubble;
            rs1_e_d  = '0;
            rs2_e_d  = '0;
            rd_e_d   = '0;
        end else if (!stallE) begin
            ctrl_e_d = ctrl_dec;
            rs1_e_d  = rs1D;
            rs2_e_d  = rs2D;
            rd_e_d   = rdD;
        end
    end

    always_comb begin
        reg_write_m_d  = reg_write_m_q;
        mem_write_m_d  = mem_write_m_q;
        result_src_m_d = result_src_m_q;
        rd_m_d         = rd_m_q;
        if (!stallM) begin
            reg_write_m_d  = ctrl_e_q.reg_write;
            mem_write_m_d  = ctrl_e_q.mem_write;
            result_src_m_d = ctrl_e_q.result_src;
            rd_m_d         = rd_e_q;
        end
    end

    // While memory stalls, M is held and W takes a bubble each cycle.
    always_comb begin
        reg_write_w_d  = reg_write_m_q;
        result_src_w_d = result_src_m_q;
        rd_w_d         = rd_m_q;
        if (stallM) begin
            reg_write_w_d  = 1'b0;
            result_src_w_d = ResAlu;
            rd_w_d         = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_e_q       <= CtrlBubble;
            rs1_e_q        <= '0;
            rs2_e_q        <= '0;
            rd_e_q         <= '0;
            reg_write_m_q  <= 1'b0;
            mem_write_m_q  <= 1'b0;
            result_src_m_q <= ResAlu;
            rd_m_q         <= '0;
            reg_write_w_q  <= 1'b0;
            result_src_w_q <= ResAlu;
            rd_w_q         <= '0;
        end else begin
            ctrl_e_q       <= ctrl_e_d;
            rs1_e_q        <= rs1_e_d;
            rs2_e_q        <= rs2_e_d;
            rd_e_q         <= rd_e_d;
            reg_write_m_q  <= reg_write_m_d;
            mem_write_m_q  <= mem_write_m_d;
            result_src_m_q <= result_src_m_d;
            rd_m_q         <= rd_m_d;
            reg_write_w_q  <= reg_write_w_d;
            result_src_w_q <= result_src_w_d;
            rd_w_q         <= rd_w_d;
        end
    end

    assign mem_accessM = mem_write_m_q | (result_src_m_q == ResMem);

    hazard_unit #(
        .REG_AW      (REG_AW),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_hazard_unit (
        .clk         (clk),
        .reset       (reset),
        .rs1D        (rs1D),
        .rs2D        (rs2D),
        .rs1E        (rs1_e_q),
        .rs2E        (rs2_e_q),
        .rdE         (rd_e_q),
        .reg_writeE  (ctrl_e_q.reg_write),
        .result_srcE (ctrl_e_q.result_src),
        .branchE     (ctrl_e_q.branch),
        .jumpE       (ctrl_e_q.jump),
        .jalrE       (ctrl_e_q.jalr),
        .zeroE       (zeroE),
        .rdM         (rd_m_q),
        .reg_writeM  (reg_write_m_q),
        .mem_accessM (mem_accessM),
        .rdW         (rd_w_q),
        .reg_writeW  (reg_write_w_q),
        .dmem_ready  (dmem_ready),
        .fwd_aE      (fwd_aE),
        .fwd_bE      (fwd_bE),
        .pcsrcE      (pcsrcE),
        .stallF      (stallF),
        .stallD      (stallD),
        .stallE      (stallE),
        .stallM      (stallM),
        .flushD      (flushD),
        .flushE      (flushE),
        .mem_err     (mem_err)
    );

    assign alu_controlE = ctrl_e_q.alu_control;
    assign alu_srcE     = ctrl_e_q.alu_src;
    assign mem_writeM   = mem_write_m_q;
    assign reg_writeW   = reg_write_w_q;
    assign result_srcW  = result_src_w_q;
    assign rdW          = rd_w_q;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller; the bench plays the fetch/decode register by hand.
module tb_pipe_controller;

    logic        clk, reset, zeroE, dmem_ready;
    logic [31:0] instrD;
    logic [1:0]  imm_srcD, fwd_aE, fwd_bE, pcsrcE, result_srcW;
    logic [2:0]  alu_controlE;
    logic        alu_srcE, mem_writeM, reg_writeW, mem_err;
    logic [4:0]  rdW;
    logic        stallF, stallD, stallE, stallM, flushD, flushE;

    int n_tests, n_fail;

    pipe_controller #(
        .REG_AW      (5),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .instrD       (instrD),
        .zeroE        (zeroE),
        .dmem_ready   (dmem_ready),
        .imm_srcD     (imm_srcD),
        .alu_controlE (alu_controlE),
        .alu_srcE     (alu_srcE),
        .fwd_aE       (fwd_aE),
        .fwd_bE       (fwd_bE),
        .pcsrcE       (pcsrcE),
        .mem_writeM   (mem_writeM),
        .reg_writeW   (reg_writeW),
        .result_srcW  (result_srcW),
        .rdW          (rdW),
        .stallF       (stallF),
        .stallD       (stallD),
        .stallE       (stallE),
        .stallM       (stallM),
        .flushD       (flushD),
        .flushE       (flushE),
        .mem_err      (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] ADD5 = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd5, 7'b0110011};
    localparam logic [31:0] SUB6 = {7'b0100000, 5'd3, 5'd5, 3'b000, 5'd6, 7'b0110011};
    localparam logic [31:0] LW7  = {12'd0, 5'd0, 3'b010, 5'd7, 7'b0000011};
    localparam logic [31:0] ADD8 = {7'b0000000, 5'd7, 5'd7, 3'b000, 5'd8, 7'b0110011};
    localparam logic [31:0] ADD9 = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd9, 7'b0110011};
    localparam logic [31:0] BEQ  = {7'b0, 5'd0, 5'd0, 3'b000, 5'b0, 7'b1100011};
    localparam logic [31:0] JALR = {12'd0, 5'd2, 3'b000, 5'd1, 7'b1100111};
    localparam logic [31:0] JAL  = {20'd0, 5'd0, 7'b1101111};
    localparam logic [31:0] SW   = {7'b0, 5'd1, 5'd2, 3'b010, 5'b0, 7'b0100011};
    localparam logic [31:0] LW10 = {12'd0, 5'd0, 3'b010, 5'd10, 7'b0000011};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic z, input logic rdy);
        instrD     = ins;
        zeroE      = z;
        dmem_ready = rdy;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            drive(NOP, 1'b0, 1'b1);
            tick();
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        drive(NOP, 1'b0, 1'b1);
        tick();
        tick();
        check_eq("rst_reg_writeW", reg_writeW, 0);
        check_eq("rst_rdW", rdW, 0);
        check_eq("rst_mem_writeM", mem_writeM, 0);
        check_eq("rst_stalls", {stallF, stallD, stallE, stallM}, 0);
        check_eq("rst_flushes", {flushD, flushE}, 0);
        check_eq("rst_pcsrc_fwd", {pcsrcE, fwd_aE, fwd_bE}, 0);
        check_eq("rst_mem_err", mem_err, 0);
        reset = 1'b0;

        // add x5,x1,x2 ; sub x6,x5,x3
        drive(ADD5, 1'b0, 1'b1);
        check_eq("a_imm_src_r", imm_srcD, 0);
        tick();
        drive(SUB6, 1'b0, 1'b1);
        check_eq("a_alu_add", alu_controlE, 3'b000);
        check_eq("a_alu_src", alu_srcE, 0);
`ifdef PIPE_CTRL_FORWARDING_EN
        check_eq("a_no_stall", {stallF, stallD, flushE}, 3'b000);
        tick();
        drive(NOP, 1'b0, 1'b1);
        check_eq("a_fwd_a_m", fwd_aE, 2'b10);
        check_eq("a_fwd_b_rf", fwd_bE, 2'b00);
        check_eq("a_alu_sub", alu_controlE, 3'b001);
        tick();
        check_eq("a_wb", {reg_writeW, rdW}, {1'b1, 5'd5});
`else
        check_eq("a_raw_e", {stallF, stallD, flushE}, 3'b111);
        tick();
        drive(SUB6, 1'b0, 1'b1);
        check_eq("a_raw_m", {stallF, stallD, flushE}, 3'b111);
        tick();
        drive(SUB6, 1'b0, 1'b1);
        check_eq("a_raw_w_free", {stallF, stallD, flushE}, 3'b000);
        check_eq("a_wb", {reg_writeW, rdW}, {1'b1, 5'd5});
        tick();
        drive(NOP, 1'b0, 1'b1);
        check_eq("a_fwd_a_off", fwd_aE, 2'b00);
        check_eq("a_alu_sub", alu_controlE, 3'b001);
`endif
        tick();
        idle(3);

        // lw x7,0(x0) ; add x8,x7,x7
        drive(LW7, 1'b0, 1'b1);
        check_eq("b_imm_src_i", imm_srcD, 0);
        check_eq("b_no_stall", {stallF, stallD, flushE}, 3'b000);
        tick();
        drive(ADD8, 1'b0, 1'b1);
        check_eq("b_load_use", {stallF, stallD, flushE}, 3'b111);
        tick();
`ifdef PIPE_CTRL_FORWARDING_EN
        drive(ADD8, 1'b0, 1'b1);
        check_eq("b_one_stall", {stallF, stallD, flushE}, 3'b000);
        tick();
        drive(NOP, 1'b0, 1'b1);
        check_eq("b_fwd_ab_w", {fwd_aE, fwd_bE}, 4'b0101);
        check_eq("b_wb_load", {reg_writeW, result_srcW, rdW}, {1'b1, 2'b01, 5'd7});
`else
        drive(ADD8, 1'b0, 1'b1);
        check_eq("b_raw_m", {stallF, stallD, flushE}, 3'b111);
        tick();
        drive(ADD8, 1'b0, 1'b1);
        check_eq("b_raw_w_free", {stallF, stallD, flushE}, 3'b000);
        check_eq("b_wb_load", {reg_writeW, result_srcW, rdW}, {1'b1, 2'b01, 5'd7});
        tick();
        drive(NOP, 1'b0, 1'b1);
        check_eq("b_fwd_off", {fwd_aE, fwd_bE}, 4'b0000);
`endif
        tick();
        idle(3);

        // beq taken, jalr, jal
        drive(BEQ, 1'b0, 1'b1);
        check_eq("c_imm_src_b", imm_srcD, 2'b10);
        tick();
        drive(ADD9, 1'b1, 1'b1);
        check_eq("c_beq_pcsrc", pcsrcE, 2'b01);
        check_eq("c_beq_flush", {flushD, flushE}, 2'b11);
        check_eq("c_beq_nostallF", stallF, 0);
        check_eq("c_beq_alu_sub", alu_controlE, 3'b001);
        tick();
        drive(JALR, 1'b0, 1'b1);
        check_eq("c_jalr_imm_i", imm_srcD, 2'b00);
        check_eq("c_flush_one_cycle", {flushD, flushE}, 2'b00);
        check_eq("c_pcsrc_idle", pcsrcE, 2'b00);
        tick();
        drive(NOP, 1'b0, 1'b1);
        check_eq("c_jalr_pcsrc", pcsrcE, 2'b10);
        check_eq("c_jalr_flush", {flushD, flushE}, 2'b11);
        check_eq("c_jalr_alu_src", alu_srcE, 1);
        tick();
        drive(JAL, 1'b0, 1'b1);
        check_eq("c_jal_imm_j", imm_srcD, 2'b11);
        tick();
        drive(NOP, 1'b0, 1'b1);
        check_eq("c_jal_pcsrc", pcsrcE, 2'b01);
        check_eq("c_jalr_wb", {reg_writeW, result_srcW, rdW}, {1'b1, 2'b10, 5'd1});
        tick();
        idle(3);

        // sw with three memory-wait cycles
        drive(SW, 1'b0, 1'b1);
        check_eq("d_imm_src_s", imm_srcD, 2'b01);
        tick();
        idle(1);
        for (int i = 0; i < 3; i++) begin
            drive(NOP, 1'b0, 1'b0);
            check_eq($sformatf("d_stall%0d", i), {stallF, stallD, stallE, stallM}, 4'hf);
            check_eq($sformatf("d_memw%0d", i), mem_writeM, 1);
            check_eq($sformatf("d_wb_off%0d", i), reg_writeW, 0);
            check_eq($sformatf("d_noflush%0d", i), {flushD, flushE}, 0);
            tick();
        end
        drive(NOP, 1'b0, 1'b1);
        check_eq("d_release", {stallF, stallD, stallE, stallM}, 0);
        check_eq("d_memw_last", mem_writeM, 1);
        check_eq("d_no_err", mem_err, 0);
        tick();
        drive(NOP, 1'b0, 1'b1);
        check_eq("d_memw_done", mem_writeM, 0);
        check_eq("d_no_err2", mem_err, 0);
        tick();
        idle(2);

        // lw x10 with dmem_ready held low past the timeout of 4
        drive(LW10, 1'b0, 1'b1);
        tick();
        idle(1);
        for (int i = 0; i < 6; i++) begin
            drive(NOP, 1'b0, 1'b0);
            check_eq($sformatf("e_stallM%0d", i), stallM, 1);
            check_eq($sformatf("e_wb_bubble%0d", i), reg_writeW, 0);
            check_eq($sformatf("e_mem_err%0d", i), mem_err, (i >= 4) ? 1 : 0);
            tick();
        end
        drive(NOP, 1'b0, 1'b1);
        check_eq("e_err_sticky", mem_err, 1);
        check_eq("e_release", {stallF, stallD, stallE, stallM}, 0);
        tick();
        drive(NOP, 1'b0, 1'b1);
        check_eq("e_wb_load", {reg_writeW, result_srcW, rdW}, {1'b1, 2'b01, 5'd10});
        check_eq("e_err_sticky2", mem_err, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(NOP, 1'b0, 1'b1);
        check_eq("e_err_cleared", mem_err, 0);
        tick();
        idle(2);

        // memory wait coincident with a taken beq in E
        drive(SW, 1'b0, 1'b1);
        tick();
        drive(BEQ, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(NOP, 1'b1, 1'b0);
            check_eq($sformatf("f_stall%0d", i), {stallF, stallD, stallE, stallM}, 4'hf);
            check_eq($sformatf("f_noflush%0d", i), {flushD, flushE}, 2'b00);
            tick();
        end
        drive(NOP, 1'b1, 1'b1);
        check_eq("f_flush", {flushD, flushE}, 2'b11);
        check_eq("f_pcsrc", pcsrcE, 2'b01);
        check_eq("f_nostall", {stallF, stallM}, 2'b00);
        tick();
        drive(NOP, 1'b0, 1'b1);
        check_eq("f_flush_done", {flushD, flushE}, 2'b00);
        tick();
        idle(2);

        // reset in the middle of a memory stall
        drive(SW, 1'b0, 1'b1);
        tick();
        idle(1);
        drive(NOP, 1'b0, 1'b0);
        check_eq("g_stalled", stallM, 1);
        tick();
        reset = 1'b1;
        drive(NOP, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        drive(NOP, 1'b0, 1'b0);
        check_eq("g_no_residual", {stallF, stallD, stallE, stallM, flushD, flushE}, 0);
        check_eq("g_memw_clear", mem_writeM, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_controller.md
PIPE_CONTROLLER -- requirements
Module: pipe_controller

Interface
REQ-001 Parameter REG_AW, default 5: register-address width (4 selects the RV32E register file).
REQ-002 Parameter MEM_TIMEOUT, default 255: number of consecutive memory-wait cycles after which mem_err is raised.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 instrD  input  32  instruction in the Decode stage.
REQ-006 zeroE  input  1  ALU zero flag from the Execute stage.
REQ-007 dmem_ready  input  1  data memory has completed the M-stage access.
REQ-008 imm_srcD  output  2  immediate format: 00 I, 01 S, 10 B, 11 J.
REQ-009 alu_controlE  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-010 alu_srcE  output  1  1 selects the immediate as ALU operand B.
REQ-011 fwd_aE, fwd_bE  output  2 each  operand source: 00 register file, 01 W result, 10 M ALU result.
REQ-012 pcsrcE  output  2  next PC: 00 pc+4, 01 pc+imm (branch/jal), 10 ALU result (jalr).
REQ-013 mem_writeM  output  1  store strobe.
REQ-014 reg_writeW, result_srcW, rdW  output  1/2/REG_AW  write-back enable, source (00 ALU, 01 memory, 10 pc+4), and destination register.
REQ-015 stallF, stallD, stallE, stallM  output  1 each  hold the named pipeline register.
REQ-016 flushD, flushE  output  1 each  clear the named pipeline register to a bubble.
REQ-017 mem_err  output  1  sticky memory-timeout flag.

Function
REQ-018 Decode SHALL support lw, sw, R-type, I-type ALU, beq, jal and jalr; any other opcode SHALL decode as a bubble (reg_write=0, mem_write=0, no branch).
REQ-019 Control fields SHALL pipeline D->E->M->W, together with rs1/rs2 (D->E) and rd (D->E->M->W); latency from D to W is 3 cycles when there is no stall.
REQ-020 Forwarding: fwd_aE=10 when rs1E!=0, reg_writeM=1 and rs1E==rdM; otherwise 01 when rs1E!=0, reg_writeW=1 and rs1E==rdW; otherwise 00. The M stage SHALL take priority over W. fwd_bE SHALL follow the same rule using rs2E.
REQ-021 Load-use: when result_srcE==01, rdE!=0 and rdE matches rs1D or rs2D, the block SHALL assert stallF, stallD and flushE for one cycle.
REQ-022 Taken control transfer in E (beq with zeroE=1, jal, jalr) SHALL assert flushD and flushE in that cycle, drive the matching pcsrcE code, and suppress stallF.
REQ-023 Memory wait: when the M stage holds lw or sw and dmem_ready=0, the block SHALL assert stallF, stallD, stallE and stallM, insert a bubble into W, and hold mem_writeM.
REQ-024 Priority, highest first: memory wait, then taken transfer, then load-use.
REQ-025 A wait counter SHALL count consecutive memory-wait cycles and clear on dmem_ready=1. When it reaches MEM_TIMEOUT, mem_err SHALL set and remain set until reset; the counter SHALL saturate and stalling SHALL continue.
REQ-026 A bubble SHALL have reg_write=0, mem_write=0, no branch and rd=0.

Reset
REQ-027 Reset SHALL clear every E/M/W control register to a bubble, clear the wait counter, and set mem_err=0.
REQ-028 Reset SHALL take effect mid-stall or mid-flush with no residual stall; in the first cycle after reset, all stall/flush outputs SHALL be 0 unless a new condition arises.

Configuration
REQ-029 Macro PIPE_CTRL_FORWARDING_EN defined: forwarding SHALL operate per REQ-020.
REQ-030 Macro PIPE_CTRL_FORWARDING_EN undefined: fwd_aE and fwd_bE SHALL be tied to 00. Any RAW match of rs1D/rs2D against a non-zero rdE or rdM with reg_write=1 SHALL assert stallF, stallD and flushE. W-stage matches SHALL not stall, because the register file writes through.

Structure
REQ-031 Package riscv_pkg SHALL hold the opcode constants and the alu_control, result_src, pcsrc, imm_src and fwd encodings.
REQ-032 Sub-module hazard_unit SHALL contain the forwarding, stall, flush and timeout logic; decode and pipeline registers SHALL stay in pipe_controller.

Verification
REQ-033 Scenario: add x5,x1,x2 then sub x6,x5,x3 -> fwd_aE=10 in the sub's E cycle; with the macro undefined -> 2 stall cycles and fwd_aE=00.
REQ-034 Scenario: lw x7,0(x0) then add x8,x7,x7 -> stallF=stallD=flushE=1 for exactly 1 cycle, then fwd_aE=fwd_bE=01.
REQ-035 Scenario: beq x0,x0 with zeroE=1 -> pcsrcE=01, flushD=flushE=1 for 1 cycle; jalr -> pcsrcE=10.
REQ-036 Scenario: sw with dmem_ready low for 3 cycles -> all four stall outputs high for 3 cycles, mem_writeM held, reg_writeW=0 over that interval.
REQ-037 Scenario: MEM_TIMEOUT=4 and dmem_ready held low -> mem_err=1 after the 4th wait cycle and stays 1 after dmem_ready rises; reset clears it.
REQ-038 Scenario: memory wait coincident with a taken beq in E -> stalls asserted, flushD=flushE=0, and the flush occurs in the first cycle after dmem_ready=1.
